// File: rtl/lcd_responder.sv
// Receive-side HD44780-subset model: decodes driver writes into a 2x16 display buffer
// and reproduces the controller's busy timing so the design can read back the panel.
module lcd_responder #(
    parameter int unsigned BUSY_CYCLES  = 40,
    parameter int unsigned CLEAR_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_index,
    output logic [7:0] rd_char,
    output logic [7:0] bf_addr,
    output logic       busy,
    output logic       display_on,
    output logic       cursor_on,
    output logic       wr_strobe,
    output logic       overrun
);

    localparam int unsigned MaxCycles = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam logic [7:0]  Space     = 8'h20;

    logic            e_sync1_q, e_sync1_d;
    logic            e_sync2_q, e_sync2_d;
    logic            e_hist_q, e_hist_d;
    logic            cap_rs_q, cap_rs_d;
    logic            cap_rw_q, cap_rw_d;
    logic [7:0]      cap_data_q, cap_data_d;
    logic            cmd_rs_q, cmd_rs_d;
    logic [7:0]      cmd_data_q, cmd_data_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [6:0]      ac_q, ac_d;
    logic            inc_q, inc_d;
    logic            display_on_q, display_on_d;
    logic            cursor_on_q, cursor_on_d;
    logic            overrun_q, overrun_d;
    logic            sweep_q, sweep_d;
    logic [4:0]      sweep_ptr_q, sweep_ptr_d;
    logic [7:0]      buf_q [32];
    logic [7:0]      buf_d [32];
    logic [7:0]      rd_char_q, rd_char_d;
    logic [7:0]      bf_addr_q, bf_addr_d;

    logic fall;
    logic accept;
    logic is_clear;

    // DDRAM address walk: line 1 is 0x00-0x0F, line 2 is 0x40-0x4F, crossing between them.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
        if (up) begin
            if (ac == 7'h0F) return 7'h40;
            if (ac == 7'h4F) return 7'h00;
            return ac + 7'd1;
        end
        if (ac == 7'h40) return 7'h0F;
        if (ac == 7'h00) return 7'h4F;
        return ac - 7'd1;
    endfunction

    always_comb begin
        e_sync1_d    = lcd_e;
        e_sync2_d    = e_sync1_q;
        e_hist_d     = e_sync2_q;
        cap_rs_d     = cap_rs_q;
        cap_rw_d     = cap_rw_q;
        cap_data_d   = cap_data_q;
        cmd_rs_d     = cmd_rs_q;
        cmd_data_d   = cmd_data_q;
        ac_d         = ac_q;
        inc_d        = inc_q;
        display_on_d = display_on_q;
        cursor_on_d  = cursor_on_q;
        sweep_d      = sweep_q;
        sweep_ptr_d  = sweep_ptr_q;
        buf_d        = buf_q;

        // Bus is captured while E is high so the value held just before the fall is kept.
        if (e_sync2_q) begin
            cap_rs_d   = lcd_rs;
            cap_rw_d   = lcd_rw;
            cap_data_d = lcd_data;
        end

        fall        = e_hist_q & ~e_sync2_q;
        accept      = fall & ~cap_rw_q & ~busy_q;
        is_clear    = ~cap_rs_q & (cap_data_q == 8'h01);
        wr_strobe_d = accept;
        overrun_d   = overrun_q | (fall & ~cap_rw_q & busy_q);

        if (accept) begin
            cmd_rs_d   = cap_rs_q;
            cmd_data_d = cap_data_q;
        end

        if (accept) begin
            cnt_d = is_clear ? CntW'(CLEAR_CYCLES) : CntW'(BUSY_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        busy_d = (cnt_d != '0);

        if (sweep_q) begin
            buf_d[sweep_ptr_q] = Space;
            sweep_ptr_d        = sweep_ptr_q + 5'd1;
            if (sweep_ptr_q == 5'd31) begin
                sweep_d = 1'b0;
            end
        end

        if (wr_strobe_q) begin
            if (cmd_rs_q) begin
                if (ac_q[6:4] == 3'b000) begin
                    buf_d[{1'b0, ac_q[3:0]}] = cmd_data_q;
                end else if (ac_q[6:4] == 3'b100) begin
                    buf_d[{1'b1, ac_q[3:0]}] = cmd_data_q;
                end
                ac_d = ac_step(ac_q, inc_q);
            end else if (cmd_data_q[7]) begin
                ac_d = cmd_data_q[6:0];
            end else if (cmd_data_q[6:4] == 3'b000) begin
                // Shift, function set and CGRAM address fall outside this branch untouched.
                if (cmd_data_q[3]) begin
                    display_on_d = cmd_data_q[2];
                    cursor_on_d  = cmd_data_q[1];
                end else if (cmd_data_q[2]) begin
                    inc_d = cmd_data_q[1];
                end else if (cmd_data_q[1]) begin
                    ac_d = 7'h00;
                end else if (cmd_data_q[0]) begin
                    ac_d        = 7'h00;
                    inc_d       = 1'b1;
                    buf_d[0]    = Space;
                    sweep_d     = 1'b1;
                    sweep_ptr_d = 5'd1;
                end
            end
        end

        rd_char_d = buf_q[rd_index];
        bf_addr_d = {busy_d, ac_d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_sync1_q    <= 1'b0;
            e_sync2_q    <= 1'b0;
            e_hist_q     <= 1'b0;
            cap_rs_q     <= 1'b0;
            cap_rw_q     <= 1'b0;
            cap_data_q   <= 8'h00;
            cmd_rs_q     <= 1'b0;
            cmd_data_q   <= 8'h00;
            wr_strobe_q  <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            ac_q         <= 7'h00;
            inc_q        <= 1'b1;
            display_on_q <= 1'b0;
            cursor_on_q  <= 1'b0;
            overrun_q    <= 1'b0;
            sweep_q      <= 1'b0;
            sweep_ptr_q  <= 5'd0;
            for (int i = 0; i < 32; i++) begin
                buf_q[i] <= Space;
            end
            rd_char_q    <= Space;
            bf_addr_q    <= 8'h00;
        end else begin
            e_sync1_q    <= e_sync1_d;
            e_sync2_q    <= e_sync2_d;
            e_hist_q     <= e_hist_d;
            cap_rs_q     <= cap_rs_d;
            cap_rw_q     <= cap_rw_d;
            cap_data_q   <= cap_data_d;
            cmd_rs_q     <= cmd_rs_d;
            cmd_data_q   <= cmd_data_d;
            wr_strobe_q  <= wr_strobe_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            ac_q         <= ac_d;
            inc_q        <= inc_d;
            display_on_q <= display_on_d;
            cursor_on_q  <= cursor_on_d;
            overrun_q    <= overrun_d;
            sweep_q      <= sweep_d;
            sweep_ptr_q  <= sweep_ptr_d;
            buf_q        <= buf_d;
            rd_char_q    <= rd_char_d;
            bf_addr_q    <= bf_addr_d;
        end
    end

    assign rd_char    = rd_char_q;
    assign bf_addr    = bf_addr_q;
    assign busy       = busy_q;
    assign display_on = display_on_q;
    assign cursor_on  = cursor_on_q;
    assign wr_strobe  = wr_strobe_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Bench for lcd_responder: a behavioural panel model fills a scoreboard queue with expected
// readback characters, which a monitor pops and compares against rd_char.
module tb_lcd_responder;

    localparam int unsigned BusyCycles  = 40;
    localparam int unsigned ClearCycles = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic       lcd_e = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [4:0] rd_index = 5'd0;
    logic [7:0] rd_char;
    logic [7:0] bf_addr;
    logic       busy;
    logic       display_on;
    logic       cursor_on;
    logic       wr_strobe;
    logic       overrun;

    lcd_responder #(
        .BUSY_CYCLES (BusyCycles),
        .CLEAR_CYCLES(ClearCycles)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_data  (lcd_data),
        .rd_index  (rd_index),
        .rd_char   (rd_char),
        .bf_addr   (bf_addr),
        .busy      (busy),
        .display_on(display_on),
        .cursor_on (cursor_on),
        .wr_strobe (wr_strobe),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Panel model
    logic [7:0] m_buf [32];
    logic [6:0] m_ac;
    logic       m_inc, m_don, m_con, m_ovr, m_busy;
    int         m_strobes = 0;
    int         m_exp_len = 0;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        m_ac = 7'h00; m_inc = 1'b1; m_don = 1'b0; m_con = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
    endtask

    function automatic int m_index(input logic [6:0] ac);
        if (ac <= 7'h0F) return int'(ac);
        if (ac >= 7'h40 && ac <= 7'h4F) return 16 + int'(ac - 7'h40);
        return -1;
    endfunction

    task automatic model_write(input logic rs, input logic [7:0] d);
        int idx;
        if (m_busy) begin
            m_ovr = 1'b1;
            return;
        end
        m_busy = 1'b1;
        m_strobes++;
        m_exp_len = (!rs && d == 8'h01) ? ClearCycles : BusyCycles;
        if (rs) begin
            idx = m_index(m_ac);
            if (idx >= 0) m_buf[idx] = d;
            if (m_inc) m_ac = (m_ac == 7'h0F) ? 7'h40 : (m_ac == 7'h4F) ? 7'h00 : m_ac + 7'd1;
            else       m_ac = (m_ac == 7'h40) ? 7'h0F : (m_ac == 7'h00) ? 7'h4F : m_ac - 7'd1;
        end else begin
            casez (d)
                8'b1???????: m_ac = d[6:0];
                8'b00001???: begin m_don = d[2]; m_con = d[1]; end
                8'b000001??: m_inc = d[1];
                8'b0000001?: m_ac = 7'h00;
                8'b00000001: begin
                    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
                    m_ac = 7'h00; m_inc = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    // Drives one E pulse; returns five clocks after the fall so any busy period has started.
    task automatic lcd_bus(input logic rs, input logic rw, input logic [7:0] d);
        if (!rw) model_write(rs, d);
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        repeat (4) @(posedge clk);
        #1 lcd_e = 1'b0;
        repeat (5) @(posedge clk);
        #1 lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00;
    endtask

    // Monitors: strobe count and length of the most recent busy run.
    int strobe_cnt = 0;
    int busy_len   = 0;
    int last_len   = 0;
    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
        busy_len <= busy ? busy_len + 1 : 0;
        if (!busy && busy_len != 0) last_len <= busy_len;
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) check("idle_timeout", 32'd0, 32'd1);
        m_busy = 1'b0;
        @(negedge clk); #1;
        check("busy_len", last_len, m_exp_len);
    endtask

    task automatic write_idle(input logic rs, input logic [7:0] d);
        lcd_bus(rs, 1'b0, d);
        wait_idle();
    endtask

    // Readback scoreboard
    logic [7:0] rd_q [$];
    int         rd_tag_q [$];
    logic       rd_req  = 1'b0;
    logic       rd_pend = 1'b0;

    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                check("rd_queue_underflow", 32'd0, 32'd1);
            end else begin
                check($sformatf("rd_char[%0d]", rd_tag_q[0]), rd_char, rd_q[0]);
                void'(rd_q.pop_front());
                void'(rd_tag_q.pop_front());
            end
        end
    end

    task automatic readback();
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            rd_index = 5'(i);
            rd_req   = 1'b1;
            rd_q.push_back(m_buf[i]);
            rd_tag_q.push_back(i);
        end
        @(posedge clk); #1 rd_req = 1'b0;
        @(posedge clk); #1;
        check("rd_queue_drained", rd_q.size(), 32'd0);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".display_on"}, display_on, m_don);
        check({tag, ".cursor_on"}, cursor_on, m_con);
        check({tag, ".overrun"}, overrun, m_ovr);
        check({tag, ".bf_addr"}, bf_addr, {1'b0, m_ac});
        check({tag, ".strobes"}, strobe_cnt, m_strobes);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst.rd_char", rd_char, 8'h20);
        check("rst.bf_addr", bf_addr, 8'h00);
        check("rst.busy", busy, 1'b0);
        check("rst.wr_strobe", wr_strobe, 1'b0);
        check_state("rst");
        rst = 1'b1;
        readback();

        // Initialisation sequence plus a status read that must change nothing.
        write_idle(1'b0, 8'h38);
        write_idle(1'b0, 8'h0C);
        write_idle(1'b0, 8'h06);
        lcd_bus(1'b0, 1'b1, 8'h00);
        check("read.busy", busy, 1'b0);
        check_state("init");

        write_idle(1'b0, 8'h80);
        write_idle(1'b1, 8'h48);
        write_idle(1'b1, 8'h45);
        write_idle(1'b1, 8'h4C);
        write_idle(1'b1, 8'h4C);
        write_idle(1'b1, 8'h4F);
        check_state("hello");
        readback();

        // Line wrap 0x0F -> 0x40
        write_idle(1'b0, 8'h8F);
        write_idle(1'b1, 8'h41);
        write_idle(1'b1, 8'h42);
        check_state("wrap");
        readback();

        // Fill both lines, then clear with a write landing inside the clear busy time.
        write_idle(1'b0, 8'h80);
        for (int i = 0; i < 32; i++) write_idle(1'b1, 8'(8'h30 + i));
        check_state("fill");
        readback();
        lcd_bus(1'b0, 8'h01 == 8'h01 ? 1'b0 : 1'b0, 8'h01);
        repeat (5) @(posedge clk);
        lcd_bus(1'b1, 1'b0, 8'h99);
        check("clear.busy_mid", busy, 1'b1);
        check("clear.overrun", overrun, 1'b1);
        wait_idle();
        check_state("clear");
        readback();

        // Decrement across the line boundary 0x40 -> 0x0F
        write_idle(1'b0, 8'h04);
        write_idle(1'b0, 8'hC0);
        write_idle(1'b1, 8'h5A);
        write_idle(1'b1, 8'h5B);
        check_state("dec");
        readback();

        // Asynchronous reset in the middle of a busy period
        lcd_bus(1'b1, 1'b0, 8'h77);
        check("midbusy.busy", busy, 1'b1);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("arst.busy", busy, 1'b0);
        check("arst.bf_addr", bf_addr, 8'h00);
        check("arst.rd_char", rd_char, 8'h20);
        check("arst.overrun", overrun, 1'b0);
        check("arst.display_on", display_on, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        readback();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
